ftrace_event_sched: RTL and testbench

//  Collects function-trace (call/ret/tail-jump) events from the two commit slots,

---
 rtl/ftrace_event_sched.sv | 157 +++++++++++++++
 tb/tb_ftrace_event_sched.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftrace_event_sched.sv
// ftrace_event_sched: queues function-trace events (call/ret/tail-jump) from the
// two commit slots in program order and hands one per cycle to the trace hook.
// It also tracks the architectural call depth as events are consumed.
// Ports:
//   clock, reset               core clock, synchronous active-low reset
//   trace_en                   gate for new events (queued events always drain)
//   c{0,1}_*                   commit slot event inputs (c0 is older than c1)
//   in_ready                   >= 2 free entries; commit stalls while low
//   out_valid/out_ready/out_*  head-of-queue handshake and event fields
//   call_depth, depth_err      running call depth and sticky under/overflow flag
//   drop_cnt                   saturating count of events lost while in_ready low
module ftrace_event_sched #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DEPTH_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               trace_en,
  input  logic               c0_valid,
  input  logic               c0_func,
  input  logic [31:0]        c0_pc,
  input  logic [31:0]        c0_nextpc,
  input  logic               c0_is_jal,
  input  logic               c0_is_ret,
  input  logic               c0_is_rd0,
  input  logic               c1_valid,
  input  logic               c1_func,
  input  logic [31:0]        c1_pc,
  input  logic [31:0]        c1_nextpc,
  input  logic               c1_is_jal,
  input  logic               c1_is_ret,
  input  logic               c1_is_rd0,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_nextpc,
  output logic               out_is_jal,
  output logic               out_is_ret,
  output logic               out_is_rd0,
  output logic [DEPTH_W-1:0] call_depth,
  output logic               depth_err,
  output logic [15:0]        drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] nextpc;
    logic        is_jal;
    logic        is_ret;
    logic        is_rd0;
  } ev_t;

  ev_t              mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  ev_t              ev0_data;
  ev_t              ev1_data;
  ev_t              head;
  logic             ev0;
  logic             ev1;
  logic [1:0]       n_ev;
  logic [1:0]       pushes;
  logic [1:0]       drops;
  logic             pop;
  logic [CNT_W-1:0] count_next;
  logic [DEPTH_W-1:0] depth_next;
  logic             err_set;
  logic [16:0]      drop_sum;
  logic [15:0]      drop_next;

  // Slot events and push/drop accounting; acceptance depends only on the
  // registered in_ready so there is no comb path from c* or out_ready to it.
  always_comb begin
    ev0      = c0_valid & c0_func & trace_en;
    ev1      = c1_valid & c1_func & trace_en;
    ev0_data = '{pc: c0_pc, nextpc: c0_nextpc, is_jal: c0_is_jal,
                 is_ret: c0_is_ret, is_rd0: c0_is_rd0};
    ev1_data = '{pc: c1_pc, nextpc: c1_nextpc, is_jal: c1_is_jal,
                 is_ret: c1_is_ret, is_rd0: c1_is_rd0};
    n_ev     = 2'(ev0) + 2'(ev1);
    pushes   = in_ready ? n_ev : 2'd0;
    drops    = in_ready ? 2'd0 : n_ev;
    pop      = out_valid & out_ready;
    count_next = count + CNT_W'(pushes) - CNT_W'(pop);
    drop_sum  = {1'b0, drop_cnt} + 17'(drops);
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Call-depth update driven by the event leaving the queue.
  always_comb begin
    depth_next = call_depth;
    err_set    = 1'b0;
    if (pop) begin
      if (head.is_ret) begin
        if (call_depth == '0) err_set = 1'b1;
        else                  depth_next = call_depth - DEPTH_W'(1);
      end else if (!head.is_rd0) begin
        if (call_depth == '1) err_set = 1'b1;
        else                  depth_next = call_depth + DEPTH_W'(1);
      end
    end
  end

  // Queue storage and pointers; both pointers wrap modulo DEPTH.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (in_ready) begin
        if (ev0) begin
          mem[wr_ptr] <= ev0_data;
          if (ev1) mem[wr_ptr + PTR_W'(1)] <= ev1_data;
        end else if (ev1) begin
          mem[wr_ptr] <= ev1_data;
        end
      end
      wr_ptr <= wr_ptr + PTR_W'(pushes);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count_next;
    end
  end

  // Registered status outputs, computed from the next occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      call_depth <= '0;
      depth_err  <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      in_ready   <= (CNT_W'(DEPTH) - count_next) >= CNT_W'(2);
      out_valid  <= count_next != '0;
      call_depth <= depth_next;
      depth_err  <= depth_err | err_set;
      drop_cnt   <= drop_next;
    end
  end

  // Head fields are read straight from storage and hold while not popped.
  assign head       = mem[rd_ptr];
  assign out_pc     = head.pc;
  assign out_nextpc = head.nextpc;
  assign out_is_jal = head.is_jal;
  assign out_is_ret = head.is_ret;
  assign out_is_rd0 = head.is_rd0;

endmodule

// File: tb/tb_ftrace_event_sched.sv
module tb_ftrace_event_sched;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned DEPTH_W = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic trace_en = 1'b1;
  logic c0_valid = 1'b0, c0_func = 1'b0, c0_is_jal = 1'b0, c0_is_ret = 1'b0, c0_is_rd0 = 1'b0;
  logic c1_valid = 1'b0, c1_func = 1'b0, c1_is_jal = 1'b0, c1_is_ret = 1'b0, c1_is_rd0 = 1'b0;
  logic [31:0] c0_pc = '0, c0_nextpc = '0, c1_pc = '0, c1_nextpc = '0;
  logic in_ready, out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_pc, out_nextpc;
  logic out_is_jal, out_is_ret, out_is_rd0;
  logic [DEPTH_W-1:0] call_depth;
  logic depth_err;
  logic [15:0] drop_cnt;

  ftrace_event_sched #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
    .clock(clock), .reset(reset), .trace_en(trace_en),
    .c0_valid(c0_valid), .c0_func(c0_func), .c0_pc(c0_pc), .c0_nextpc(c0_nextpc),
    .c0_is_jal(c0_is_jal), .c0_is_ret(c0_is_ret), .c0_is_rd0(c0_is_rd0),
    .c1_valid(c1_valid), .c1_func(c1_func), .c1_pc(c1_pc), .c1_nextpc(c1_nextpc),
    .c1_is_jal(c1_is_jal), .c1_is_ret(c1_is_ret), .c1_is_rd0(c1_is_rd0),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_nextpc(out_nextpc), .out_is_jal(out_is_jal),
    .out_is_ret(out_is_ret), .out_is_rd0(out_is_rd0),
    .call_depth(call_depth), .depth_err(depth_err), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] nextpc;
    logic        jal;
    logic        ret;
    logic        rd0;
  } ev_s;

  // Reference model: an in-order queue plus plain integer bookkeeping.
  ev_s mq[$];
  int  m_depth = 0;
  bit  m_err = 0;
  int  m_drop = 0;
  int  total = 0;
  int  bad = 0;

  // Advance the model by the rules for this cycle, then clock the DUT.
  task automatic tick();
    bit e0, e1, rdy;
    ev_s h, a, b;
    if (!reset) begin
      mq.delete();
      m_depth = 0; m_err = 0; m_drop = 0;
    end else begin
      e0  = c0_valid && c0_func && trace_en;
      e1  = c1_valid && c1_func && trace_en;
      rdy = (int'(DEPTH) - mq.size()) >= 2;
      if (mq.size() != 0 && out_ready) begin
        h = mq.pop_front();
        if (h.ret) begin
          if (m_depth == 0) m_err = 1; else m_depth--;
        end else if (!h.rd0) begin
          if (m_depth == 255) m_err = 1; else m_depth++;
        end
      end
      a = '{pc: c0_pc, nextpc: c0_nextpc, jal: c0_is_jal, ret: c0_is_ret, rd0: c0_is_rd0};
      b = '{pc: c1_pc, nextpc: c1_nextpc, jal: c1_is_jal, ret: c1_is_ret, rd0: c1_is_rd0};
      if (rdy) begin
        if (e0) mq.push_back(a);
        if (e1) mq.push_back(b);
      end else begin
        m_drop = m_drop + int'(e0) + int'(e1);
        if (m_drop > 65535) m_drop = 65535;
      end
    end
    @(posedge clock);
    #1;
  endtask

  // kind: 0 = call, 1 = ret, 2 = tail jump
  task automatic set_slot(input int slot, input logic [31:0] pc, input logic [31:0] npc, input int kind);
    logic jal, ret, rd0;
    jal = (kind == 0);
    ret = (kind == 1);
    rd0 = (kind != 0);
    if (slot == 0) begin
      c0_valid = 1; c0_func = 1; c0_pc = pc; c0_nextpc = npc;
      c0_is_jal = jal; c0_is_ret = ret; c0_is_rd0 = rd0;
    end else begin
      c1_valid = 1; c1_func = 1; c1_pc = pc; c1_nextpc = npc;
      c1_is_jal = jal; c1_is_ret = ret; c1_is_rd0 = rd0;
    end
  endtask

  task automatic clear_slots();
    c0_valid = 0; c0_func = 0;
    c1_valid = 0; c1_func = 0;
  endtask

  task automatic do_reset();
    clear_slots();
    out_ready = 0;
    trace_en = 1;
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (call_depth !== 8'd0) begin bad++; $display("FAIL reset_call_depth got=%0d exp=0", call_depth); end
    total++; if (depth_err !== 1'b0) begin bad++; $display("FAIL reset_depth_err got=%b exp=0", depth_err); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
    total++; if (out_pc !== 32'd0) begin bad++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
  endtask

  task automatic test_single_call();
    do_reset();
    set_slot(0, 32'h8000_0000, 32'h8000_0100, 0);
    tick();
    clear_slots();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    total++; if (out_pc !== 32'h8000_0000) begin bad++; $display("FAIL single_pc got=%h exp=80000000", out_pc); end
    total++; if (out_nextpc !== 32'h8000_0100) begin bad++; $display("FAIL single_nextpc got=%h exp=80000100", out_nextpc); end
    out_ready = 1;
    tick();
    total++; if (call_depth !== 8'd1) begin bad++; $display("FAIL single_depth got=%0d exp=1", call_depth); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_call_ret();
    do_reset();
    out_ready = 1;
    set_slot(0, 32'h100, 32'h200, 0);
    set_slot(1, 32'h204, 32'h104, 1);
    tick();
    clear_slots();
    total++; if (out_pc !== 32'h100 || out_is_ret !== 1'b0) begin bad++; $display("FAIL callret_first got=%h/%b exp=100/0", out_pc, out_is_ret); end
    tick();
    total++; if (call_depth !== 8'd1) begin bad++; $display("FAIL callret_depth1 got=%0d exp=1", call_depth); end
    total++; if (out_pc !== 32'h204 || out_is_ret !== 1'b1) begin bad++; $display("FAIL callret_second got=%h/%b exp=204/1", out_pc, out_is_ret); end
    tick();
    total++; if (call_depth !== 8'd0) begin bad++; $display("FAIL callret_depth0 got=%0d exp=0", call_depth); end
    total++; if (depth_err !== 1'b0) begin bad++; $display("FAIL callret_err got=%b exp=0", depth_err); end
  endtask

  task automatic test_fill_drop();
    logic [31:0] pcv;
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_slot(0, 32'h1000 + 32'(8 * i), 32'h2000, 2);
      set_slot(1, 32'h1004 + 32'(8 * i), 32'h2000, 2);
      tick();
      total++;
      if (in_ready !== ((i < 3) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL fill_in_ready_%0d got=%b exp=%b", i, in_ready, (i < 3)); end
      total++;
      if (out_pc !== 32'h1000) begin bad++; $display("FAIL fill_head_stable_%0d got=%h exp=1000", i, out_pc); end
    end
    set_slot(0, 32'h9000, 32'h0, 0);
    set_slot(1, 32'h9004, 32'h0, 0);
    tick();
    clear_slots();
    total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL fill_drop got=%0d exp=2", drop_cnt); end
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      pcv = 32'h1000 + 32'(4 * i);
      total++;
      if (out_valid !== 1'b1 || out_pc !== pcv) begin bad++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, out_valid, out_pc, pcv); end
      tick();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_underflow();
    do_reset();
    out_ready = 1;
    set_slot(0, 32'h40, 32'h80, 1);
    tick();
    clear_slots();
    tick();
    total++; if (call_depth !== 8'd0) begin bad++; $display("FAIL under_depth got=%0d exp=0", call_depth); end
    total++; if (depth_err !== 1'b1) begin bad++; $display("FAIL under_err got=%b exp=1", depth_err); end
    for (int i = 0; i < 3; i++) begin
      set_slot(0, 32'h500 + 32'(4 * i), 32'h600, 0);
      tick();
    end
    clear_slots();
    tick();
    total++; if (call_depth !== 8'd3) begin bad++; $display("FAIL under_calls got=%0d exp=3", call_depth); end
    total++; if (depth_err !== 1'b1) begin bad++; $display("FAIL under_sticky got=%b exp=1", depth_err); end
  endtask

  task automatic test_trace_en();
    int pops;
    logic [15:0] d0;
    do_reset();
    out_ready = 0;
    set_slot(0, 32'h10, 32'h20, 0);
    set_slot(1, 32'h14, 32'h24, 2);
    tick();
    clear_slots();
    set_slot(1, 32'h18, 32'h28, 1);
    tick();
    d0 = drop_cnt;
    trace_en = 0;
    out_ready = 1;
    set_slot(0, 32'hA0, 32'hB0, 0);
    set_slot(1, 32'hA4, 32'hB4, 0);
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid === 1'b1) pops++;
      tick();
    end
    clear_slots();
    trace_en = 1;
    total++; if (pops != 3) begin bad++; $display("FAIL trace_en_pops got=%0d exp=3", pops); end
    total++; if (drop_cnt !== d0) begin bad++; $display("FAIL trace_en_drop got=%0d exp=%0d", drop_cnt, d0); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL trace_en_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1;
    set_slot(0, 32'h300, 32'h400, 0);
    tick();
    clear_slots();
    tick();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_slot(0, 32'h700 + 32'(8 * i), 32'h800, 0);
      if (i < 2) set_slot(1, 32'h704 + 32'(8 * i), 32'h800, 0);
      tick();
      clear_slots();
    end
    total++; if (call_depth !== 8'd1) begin bad++; $display("FAIL mid_pre_depth got=%0d exp=1", call_depth); end
    out_ready = 1;
    reset = 0;
    tick();
    reset = 1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    total++; if (call_depth !== 8'd0) begin bad++; $display("FAIL mid_depth got=%0d exp=0", call_depth); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_still_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_depth_overflow();
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 260; i++) begin
      set_slot(0, 32'(i * 4), 32'h0, 0);
      tick();
    end
    clear_slots();
    tick();
    total++; if (call_depth !== 8'd255) begin bad++; $display("FAIL overflow_depth got=%0d exp=255", call_depth); end
    total++; if (depth_err !== 1'b1) begin bad++; $display("FAIL overflow_err got=%b exp=1", depth_err); end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    out_ready = 0;
    set_slot(0, 32'h1, 32'h2, 2);
    set_slot(1, 32'h3, 32'h4, 2);
    for (int i = 0; i < 4 + 32768; i++) tick();
    total++; if (drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL drop_sat got=%h exp=ffff", drop_cnt); end
    tick();
    tick();
    clear_slots();
    total++; if (drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL drop_sat_hold got=%h exp=ffff", drop_cnt); end
  endtask

  // Random traffic compared every cycle against the queue model.
  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      reset    = ($urandom_range(0, 99) != 0);
      trace_en = ($urandom_range(0, 9) != 0);
      out_ready = $urandom_range(0, 1);
      c0_valid = $urandom_range(0, 1); c0_func = $urandom_range(0, 1);
      c1_valid = $urandom_range(0, 1); c1_func = $urandom_range(0, 1);
      c0_pc = $urandom; c0_nextpc = $urandom; c1_pc = $urandom; c1_nextpc = $urandom;
      c0_is_jal = $urandom_range(0, 1); c0_is_ret = $urandom_range(0, 1); c0_is_rd0 = $urandom_range(0, 1);
      c1_is_jal = $urandom_range(0, 1); c1_is_ret = $urandom_range(0, 1); c1_is_rd0 = $urandom_range(0, 1);
      tick();
      total++;
      if (in_ready !== ((int'(DEPTH) - mq.size()) >= 2)) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b size=%0d", n, in_ready, mq.size()); end
      total++;
      if (out_valid !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_out_valid cyc=%0d got=%b size=%0d", n, out_valid, mq.size()); end
      if (mq.size() != 0) begin
        total++;
        if (out_pc !== mq[0].pc || out_nextpc !== mq[0].nextpc || out_is_jal !== mq[0].jal ||
            out_is_ret !== mq[0].ret || out_is_rd0 !== mq[0].rd0) begin
          bad++;
          $display("FAIL rnd_head cyc=%0d got=%h/%h/%b%b%b exp=%h/%h/%b%b%b", n, out_pc, out_nextpc,
                   out_is_jal, out_is_ret, out_is_rd0, mq[0].pc, mq[0].nextpc, mq[0].jal, mq[0].ret, mq[0].rd0);
        end
      end
      total++;
      if (call_depth !== 8'(m_depth) || depth_err !== m_err) begin bad++; $display("FAIL rnd_depth cyc=%0d got=%0d/%b exp=%0d/%b", n, call_depth, depth_err, m_depth, m_err); end
      total++;
      if (drop_cnt !== 16'(m_drop)) begin bad++; $display("FAIL rnd_drop cyc=%0d got=%0d exp=%0d", n, drop_cnt, m_drop); end
    end
    reset = 1;
    clear_slots();
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_call_ret();
    test_fill_drop();
    test_underflow();
    test_trace_en();
    test_reset_mid();
    test_depth_overflow();
    test_random();
    test_drop_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
